// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_ctrl_pkg
// Description : Shared definitions for the core control block. Holds the flush
//               sequencer state encoding, the flushable stage count, and the bit
//               index of each stage in the flush_req/ack/busy vectors.
// Revision    : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

  // Flushable stages. The order below fixes the bit position of each stage.
  localparam int N_STG      = 8;
  localparam int STG_PW     = 0;  // page walker
  localparam int STG_IL     = 1;  // instruction loader
  localparam int STG_DEC    = 2;  // decoder
  localparam int STG_RSV1   = 3;
  localparam int STG_RSV2   = 4;
  localparam int STG_RSV3   = 5;
  localparam int STG_RSV4   = 6;
  localparam int STG_REGMNG = 7;  // register manager

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RESTART = 3'd4
  } seq_state_e;

endpackage : core_ctrl_pkg
`default_nettype wire

// File: rtl/flush_ack_tracker.sv
`default_nettype none
// ============================================================================
// Module      : flush_ack_tracker
// Description : Accumulates per-stage flush acknowledges in a sticky mask and
//               runs the flush timeout counter.
//   clk, rst  : clock, synchronous active-high reset
//   start     : clear the mask and the counter (held while the sequencer is
//               in HOLD, so FLUSH always starts clean)
//   active    : sequencer is in FLUSH; acks and counting only happen then
//   ack       : per-stage flush acknowledge
//   done      : every stage acked, including acks arriving this cycle
//   timeout   : counter reaches its terminal value this cycle, mask incomplete
//   pending   : stages still owing an ack after this cycle's acks
// Revision    : 1.0 - initial release
// ============================================================================
module flush_ack_tracker #(
  parameter int N_STG = 8,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             active,
  input  logic [N_STG-1:0] ack,
  output logic             done,
  output logic             timeout,
  output logic [N_STG-1:0] pending
);

  // The counter holds k in the (k+1)-th FLUSH cycle, so the increment that
  // would take it to all-ones happens when it currently holds all-ones-minus-1.
  localparam logic [TMO_W-1:0] C_CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] C_CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [N_STG-1:0] mask_q, mask_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [N_STG-1:0] w_mask_all;

  // Acks outside FLUSH never reach the mask.
  assign w_mask_all = mask_q | (active ? ack : '0);
  assign done       = active & (&w_mask_all);
  assign timeout    = active & ~(&w_mask_all) & (cnt_q == C_CNT_LAST);
  assign pending    = ~w_mask_all;

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (start) begin
      mask_d = '0;
      cnt_d  = '0;
    end else if (active) begin
      mask_d = w_mask_all;
      cnt_d  = cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : flush_ack_tracker
`default_nettype wire

// File: rtl/flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flush_sequencer
// Description : Sequences a pipeline flush after a commit-side redirect:
//               IDLE -> HOLD (ROB flush) -> FLUSH (per-stage flush handshake)
//               -> DRAIN (wait for idle stages) -> RESTART (fetch restart).
//   redirect_valid/pc  : redirect request and target PC
//   stg_busy           : per-stage busy, must be all-zero to leave DRAIN
//   stg_flush_ack      : per-stage flush acknowledge (FLUSH only)
//   flush_req          : per-stage flush command
//   rob_flush          : one-cycle pulse in HOLD
//   hold_fetch/seq_busy: high whenever the sequencer is not IDLE
//   restart_valid/pc   : fetch restart handshake with restart_ready
//   flush_timeout      : sticky, set when a FLUSH phase times out
//   flush_count        : completed sequences (wrapping)
// All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module flush_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int N_STG = core_ctrl_pkg::N_STG,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic [N_STG-1:0] stg_busy,
  input  logic [N_STG-1:0] stg_flush_ack,
  output logic [N_STG-1:0] flush_req,
  output logic             rob_flush,
  output logic             hold_fetch,
  output logic             restart_valid,
  output logic [PC_W-1:0]  restart_pc,
  input  logic             restart_ready,
  output logic             seq_busy,
  output logic             flush_timeout,
  output logic [15:0]      flush_count
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [N_STG-1:0] flush_req_q, flush_req_d;
  logic             rob_flush_q, rob_flush_d;
  logic             hold_fetch_q, hold_fetch_d;
  logic             restart_valid_q, restart_valid_d;
  logic             flush_timeout_q, flush_timeout_d;
  logic [15:0]      flush_count_q, flush_count_d;

  logic             w_trk_done;
  logic             w_trk_timeout;
  logic [N_STG-1:0] w_trk_pending;

  flush_ack_tracker #(
    .N_STG (N_STG),
    .TMO_W (TMO_W)
  ) u_ack_tracker (
    .clk     (clk),
    .rst     (rst),
    .start   (state_q == ST_HOLD),
    .active  (state_q == ST_FLUSH),
    .ack     (stg_flush_ack),
    .done    (w_trk_done),
    .timeout (w_trk_timeout),
    .pending (w_trk_pending)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    flush_timeout_d = flush_timeout_q;
    flush_count_d   = flush_count_q;

    // A redirect arriving mid-sequence only retargets the restart PC; the
    // flush already in progress covers the newer redirect as well.
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_trk_done) begin
          state_d = ST_DRAIN;
        end else if (w_trk_timeout) begin
          state_d         = ST_DRAIN;
          flush_timeout_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stg_busy == '0) state_d = ST_RESTART;
      end
      ST_RESTART: begin
        // Younger instructions may already have been fetched from the old
        // target, so a redirect here needs a complete new flush.
        if (redirect_valid) begin
          state_d = ST_HOLD;
        end else if (restart_ready) begin
          state_d       = ST_IDLE;
          flush_count_d = flush_count_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it.
    rob_flush_d     = (state_d == ST_HOLD);
    hold_fetch_d    = (state_d != ST_IDLE);
    restart_valid_d = (state_d == ST_RESTART);
    if (state_d != ST_FLUSH) begin
      flush_req_d = '0;
    end else if (state_q == ST_FLUSH) begin
      flush_req_d = w_trk_pending;
    end else begin
      flush_req_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pc_q            <= '0;
      flush_req_q     <= '0;
      rob_flush_q     <= 1'b0;
      hold_fetch_q    <= 1'b0;
      restart_valid_q <= 1'b0;
      flush_timeout_q <= 1'b0;
      flush_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      flush_req_q     <= flush_req_d;
      rob_flush_q     <= rob_flush_d;
      hold_fetch_q    <= hold_fetch_d;
      restart_valid_q <= restart_valid_d;
      flush_timeout_q <= flush_timeout_d;
      flush_count_q   <= flush_count_d;
    end
  end

  assign flush_req     = flush_req_q;
  assign rob_flush     = rob_flush_q;
  assign hold_fetch    = hold_fetch_q;
  assign seq_busy      = hold_fetch_q;
  assign restart_valid = restart_valid_q;
  assign restart_pc    = pc_q;
  assign flush_timeout = flush_timeout_q;
  assign flush_count   = flush_count_q;

endmodule : flush_sequencer
`default_nettype wire

// File: tb/tb_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flush_sequencer
// Description : Directed self-checking bench for flush_sequencer. Each cycle
//               the bench samples outputs 1ns after the rising edge, then
//               drives the inputs that the next rising edge will capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flush_sequencer;
  import core_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  stg_busy;
  logic [7:0]  stg_flush_ack;
  logic [7:0]  flush_req;
  logic        rob_flush;
  logic        hold_fetch;
  logic        restart_valid;
  logic [31:0] restart_pc;
  logic        restart_ready;
  logic        seq_busy;
  logic        flush_timeout;
  logic [15:0] flush_count;

  int checks = 0;
  int errors = 0;

  flush_sequencer #(.PC_W(32), .N_STG(8), .TMO_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stg_busy       (stg_busy),
    .stg_flush_ack  (stg_flush_ack),
    .flush_req      (flush_req),
    .rob_flush      (rob_flush),
    .hold_fetch     (hold_fetch),
    .restart_valid  (restart_valid),
    .restart_pc     (restart_pc),
    .restart_ready  (restart_ready),
    .seq_busy       (seq_busy),
    .flush_timeout  (flush_timeout),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pack the single-bit outputs so one comparison covers them all:
  // {rob_flush, hold_fetch, seq_busy, restart_valid, flush_timeout}
  function automatic logic [31:0] flags();
    return {27'd0, rob_flush, hold_fetch, seq_busy, restart_valid, flush_timeout};
  endfunction

  int n;
  int bad;
  logic [7:0] exp_req;

  initial begin
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hDEAD; // ignored in reset
    stg_busy = 8'h00; stg_flush_ack = 8'h00; restart_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; redirect_valid = 1'b0;

    // ---------------- reset state ----------------
    chk("rst_flush_req", {24'd0, flush_req}, 32'h0);
    chk("rst_flags", flags(), 32'h0);
    chk("rst_pc", restart_pc, 32'h0);
    chk("rst_count", {16'd0, flush_count}, 32'h0);
    tick();
    chk("rst_redirect_ignored", flags(), 32'h0);

    // ---------------- basic sequence, pc 0x1000 ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    tick(); redirect_valid = 1'b0;
    chk("b_hold_flags", flags(), 32'h1C);        // rob_flush, hold, busy
    chk("b_hold_req", {24'd0, flush_req}, 32'h0);
    tick();
    chk("b_flush_req", {24'd0, flush_req}, 32'hFF);
    chk("b_flush_flags", flags(), 32'h0C);
    tick();
    chk("b_flush_req2", {24'd0, flush_req}, 32'hFF);
    stg_flush_ack = 8'hFF;
    tick(); stg_flush_ack = 8'h00;
    chk("b_drain_req", {24'd0, flush_req}, 32'h0);
    chk("b_drain_flags", flags(), 32'h0C);
    tick();
    chk("b_restart_flags", flags(), 32'h0E);
    chk("b_restart_pc", restart_pc, 32'h1000);
    restart_ready = 1'b1;
    tick(); restart_ready = 1'b0;
    chk("b_idle_flags", flags(), 32'h0);
    chk("b_count", {16'd0, flush_count}, 32'd1);

    // ---------------- staggered acks ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h1100;
    tick(); redirect_valid = 1'b0;
    tick();
    chk("s_first_req", {24'd0, flush_req}, 32'hFF);
    exp_req = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      stg_flush_ack = 8'h01 << k;
      exp_req[k] = 1'b0;
      tick();
      chk($sformatf("s_req_after_ack%0d", k), {24'd0, flush_req}, {24'd0, exp_req});
      chk($sformatf("s_no_restart%0d", k), {31'd0, restart_valid}, 32'd0);
    end
    stg_flush_ack = 8'h00;
    tick();
    chk("s_restart_flags", flags(), 32'h0E);
    chk("s_restart_pc", restart_pc, 32'h1100);
    restart_ready = 1'b1;
    tick(); restart_ready = 1'b0;
    chk("s_count", {16'd0, flush_count}, 32'd2);

    // ---------------- timeout: stage RSV3 never acks ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h1200;
    tick(); redirect_valid = 1'b0;
    tick();
    n = 0;
    while (flush_req != 8'h00 && n < 400) begin
      if (n == 1) chk("t_pending", {24'd0, flush_req}, 32'h1 << STG_RSV3);
      stg_flush_ack = (n == 0) ? ~(8'h01 << STG_RSV3) : 8'h00;
      n++;
      tick();
    end
    stg_flush_ack = 8'h00;
    chk("t_flush_cycles", n, 32'd255);
    chk("t_drain_flags", flags(), 32'h0D);       // hold, busy, timeout
    tick();
    chk("t_restart_flags", flags(), 32'h0F);
    restart_ready = 1'b1;
    tick(); restart_ready = 1'b0;
    chk("t_idle_flags", flags(), 32'h01);        // timeout stays sticky
    chk("t_count", {16'd0, flush_count}, 32'd3);

    // ---------------- redirect in DRAIN then in RESTART ----------------
    stg_busy = 8'h01;
    redirect_valid = 1'b1; redirect_pc = 32'h1300;
    tick(); redirect_valid = 1'b0;
    stg_flush_ack = 8'hFF;                       // HOLD: must be ignored
    tick();
    chk("r_req_ack_ignored", {24'd0, flush_req}, 32'hFF);
    tick(); stg_flush_ack = 8'h00;
    redirect_valid = 1'b1; redirect_pc = 32'h2000;  // in DRAIN
    tick(); redirect_valid = 1'b0;
    chk("r_drain_pc", restart_pc, 32'h2000);
    chk("r_drain_flags", flags(), 32'h0D);
    stg_busy = 8'h00;
    tick();
    chk("r_restart_pc", restart_pc, 32'h2000);
    chk("r_restart_flags", flags(), 32'h0F);
    redirect_valid = 1'b1; redirect_pc = 32'h3000; restart_ready = 1'b1;
    tick(); redirect_valid = 1'b0; restart_ready = 1'b0;
    chk("r_rehold_flags", flags(), 32'h1D);
    chk("r_rehold_pc", restart_pc, 32'h3000);
    chk("r_rehold_count", {16'd0, flush_count}, 32'd3);
    tick();
    chk("r_reflush_req", {24'd0, flush_req}, 32'hFF);
    stg_flush_ack = 8'hFF;
    tick(); stg_flush_ack = 8'h00;
    tick();
    chk("r_final_pc", restart_pc, 32'h3000);
    chk("r_final_flags", flags(), 32'h0F);
    restart_ready = 1'b1;
    tick(); restart_ready = 1'b0;
    chk("r_count", {16'd0, flush_count}, 32'd4);

    // ---------------- reset in FLUSH ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    tick(); redirect_valid = 1'b0;
    tick();
    chk("x_req_before", {24'd0, flush_req}, 32'hFF);
    rst = 1'b1; stg_flush_ack = 8'hFF;
    tick(); rst = 1'b0;
    chk("x_req", {24'd0, flush_req}, 32'h0);
    chk("x_flags", flags(), 32'h0);
    chk("x_pc", restart_pc, 32'h0);
    chk("x_count", {16'd0, flush_count}, 32'h0);
    tick(); stg_flush_ack = 8'h00;
    chk("x_idle_req", {24'd0, flush_req}, 32'h0);
    chk("x_idle_flags", flags(), 32'h0);

    // ---------------- long DRAIN with stage busy ----------------
    stg_busy = 8'h10;
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    tick(); redirect_valid = 1'b0;
    tick();
    stg_flush_ack = 8'hFF;
    tick(); stg_flush_ack = 8'h00;          // first DRAIN cycle, busy high
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (restart_valid !== 1'b0 || hold_fetch !== 1'b1) bad++;
      if (k == 19) stg_busy = 8'h00;        // drop after 20 busy cycles
      tick();
    end
    chk("d_held_in_drain", bad, 32'd0);
    chk("d_restart_valid", {31'd0, restart_valid}, 32'd1);
    chk("d_restart_pc", restart_pc, 32'h5000);
    restart_ready = 1'b1;
    tick(); restart_ready = 1'b0;
    chk("d_count", {16'd0, flush_count}, 32'd1);
    chk("d_idle_flags", flags(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_flush_sequencer
`default_nettype wire
